// File: rtl/pipe_skid_x4.sv
// Two-entry registered valid/ready skid stage; q_data, q_valid and i_ready all come straight from flops.
// Optional build macro PIPE_SKID_X4_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module pipe_skid_x4 #(
   parameter int WIDTH = 8
) (
   input  logic             ck,
   input  logic             nrst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [WIDTH-1:0] q_data,
   output logic             q_valid,
   input  logic             q_ready
`ifdef PIPE_SKID_X4_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             r_qvalid;
   logic             r_iready;
   logic             w_in;
   logic             w_out;
   logic             w_ld_main_in;
   logic             w_ld_main_skid;
   logic             w_ld_skid;

   assign w_in  = i_valid & r_iready;
   assign w_out = r_qvalid & q_ready;

   always_comb begin
      w_nxt          = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_in) begin
               w_nxt        = S_ONE;
               w_ld_main_in = 1'b1;
            end
         end
         S_ONE: begin
            if (w_in && w_out) begin
               w_ld_main_in = 1'b1;
            end else if (w_in) begin
               w_nxt     = S_FULL;
               w_ld_skid = 1'b1;
            end else if (w_out) begin
               w_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            // i_ready is low here, so only the drain side can move
            if (w_out) begin
               w_nxt          = S_ONE;
               w_ld_main_skid = 1'b1;
            end
         end
         default: w_nxt = S_EMPTY;
      endcase
   end

   // Output flags are registered from the next state so no input reaches them combinationally
   always_ff @(posedge ck) begin
      if (!nrst) begin
         r_state  <= S_EMPTY;
         r_main   <= '0;
         r_skid   <= '0;
         r_qvalid <= 1'b0;
         r_iready <= 1'b1;
      end else begin
         r_state  <= w_nxt;
         r_qvalid <= (w_nxt != S_EMPTY);
         r_iready <= (w_nxt != S_FULL);
         if (w_ld_main_in) begin
            r_main <= i_data;
         end else if (w_ld_main_skid) begin
            r_main <= r_skid;
         end
         if (w_ld_skid) begin
            r_skid <= i_data;
         end
      end
   end

   assign q_data  = r_main;
   assign q_valid = r_qvalid;
   assign i_ready = r_iready;

`ifdef PIPE_SKID_X4_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge ck) begin
      if (!nrst) begin
         r_stall_cnt <= '0;
      end else if (r_qvalid && !q_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_x4.sv
// Randomized and directed bench for pipe_skid_x4, checked against a queue-based FIFO model.
// Build with PIPE_SKID_X4_STALL_CNT_EN defined to also exercise the stall counter.
module tb_pipe_skid_x4;

   logic       ck;
   logic       nrst;
   logic [7:0] i_data;
   logic       i_valid;
   logic       i_ready;
   logic [7:0] q_data;
   logic       q_valid;
   logic       q_ready;
`ifdef PIPE_SKID_X4_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: the stage is a 2-deep FIFO whose head is q_data
   logic [7:0] m_q[$];
   int         m_stall = 0;

   pipe_skid_x4 #(.WIDTH(8)) dut (
      .ck      (ck),
      .nrst    (nrst),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .q_data  (q_data),
      .q_valid (q_valid),
      .q_ready (q_ready)
`ifdef PIPE_SKID_X4_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // One rising edge, with the model advanced from the inputs held across it
   task automatic tick();
      bit in_x;
      bit out_x;
      bit stall_x;
      in_x    = i_valid && (m_q.size() < 2);
      out_x   = q_ready && (m_q.size() > 0);
      stall_x = !q_ready && (m_q.size() > 0);
      @(posedge ck);
      if (!nrst) begin
         m_q.delete();
         m_stall = 0;
      end else begin
         if (stall_x && m_stall < 65535) m_stall++;
         if (out_x) void'(m_q.pop_front());
         if (in_x) m_q.push_back(i_data);
      end
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0; i_valid = 1'b1; i_data = 8'hAA; q_ready = 1'b1;
      tick(); tick();
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_qvalid: got %b want 0", q_valid); end
      total++; if (q_data !== 8'h00) begin bad++; $display("FAIL reset_qdata: got %h want 00", q_data); end
      total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_iready: got %b want 1", i_ready); end
      nrst = 1'b1; i_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_noemit: got %b want 0", q_valid); end
      end
   endtask

   task automatic test_streaming();
      q_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         i_valid = 1'b1; i_data = 8'(k);
         tick();
         total++;
         if (q_valid !== 1'b1 || q_data !== 8'(k) || i_ready !== 1'b1) begin
            bad++; $display("FAIL stream_%0d: got v=%b d=%h r=%b want v=1 d=%h r=1", k, q_valid, q_data, i_ready, 8'(k));
         end
      end
      i_valid = 1'b0;
      tick();
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", q_valid); end
   endtask

   task automatic test_backpressure();
      q_ready = 1'b0;
      i_valid = 1'b1; i_data = 8'h11; tick();
      i_data = 8'h22; tick();
      i_valid = 1'b0; i_data = 8'hEE;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (i_ready !== 1'b0 || q_valid !== 1'b1 || q_data !== 8'h11) begin
            bad++; $display("FAIL bp_hold_%0d: got r=%b v=%b d=%h want r=0 v=1 d=11", k, i_ready, q_valid, q_data);
         end
         tick();
      end
      q_ready = 1'b1;
      tick();
      total++;
      if (q_valid !== 1'b1 || q_data !== 8'h22 || i_ready !== 1'b1) begin
         bad++; $display("FAIL bp_second: got v=%b d=%h r=%b want v=1 d=22 r=1", q_valid, q_data, i_ready);
      end
      tick();
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", q_valid); end
   endtask

   task automatic test_simultaneous();
      q_ready = 1'b0; i_valid = 1'b1; i_data = 8'h33; tick();
      i_valid = 1'b0; tick();
      total++; if (q_data !== 8'h33 || i_ready !== 1'b1) begin bad++; $display("FAIL sim_hold: got d=%h r=%b want d=33 r=1", q_data, i_ready); end
      q_ready = 1'b1; i_valid = 1'b1; i_data = 8'h44; tick();
      total++;
      if (q_valid !== 1'b1 || q_data !== 8'h44 || i_ready !== 1'b1) begin
         bad++; $display("FAIL sim_swap: got v=%b d=%h r=%b want v=1 d=44 r=1", q_valid, q_data, i_ready);
      end
      i_valid = 1'b0; tick();
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL sim_empty: got %b want 0", q_valid); end
   endtask

   task automatic test_midreset();
      q_ready = 1'b0; i_valid = 1'b1; i_data = 8'h55; tick();
      i_data = 8'h66; tick();
      i_valid = 1'b0;
      total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL mr_full: got r=%b want 0", i_ready); end
      nrst = 1'b0; tick();
      nrst = 1'b1;
      total++; if (q_valid !== 1'b0 || i_ready !== 1'b1) begin bad++; $display("FAIL mr_clear: got v=%b r=%b want v=0 r=1", q_valid, i_ready); end
      q_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL mr_noemit_%0d: got v=%b d=%h want v=0", k, q_valid, q_data); end
      end
   endtask

   task automatic test_random();
      int errs_before;
      errs_before = bad;
      for (int k = 0; k < 600; k++) begin
         i_valid = ($urandom_range(0, 3) != 0);
         i_data  = 8'($urandom);
         q_ready = ($urandom_range(0, 2) != 0);
         nrst    = ($urandom_range(0, 79) != 0);
         tick();
         total++;
         if (q_valid !== (m_q.size() > 0) || i_ready !== (m_q.size() < 2) ||
             (m_q.size() > 0 && q_data !== m_q[0])) begin
            bad++;
            $display("FAIL rand_%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h", k, q_valid, i_ready, q_data,
                     m_q.size() > 0, m_q.size() < 2, (m_q.size() > 0) ? m_q[0] : 8'h00);
         end
`ifdef PIPE_SKID_X4_STALL_CNT_EN
         total++;
         if (stall_cnt !== 16'(m_stall)) begin bad++; $display("FAIL rand_stall_%0d: got %0d want %0d", k, stall_cnt, m_stall); end
`endif
         if (bad - errs_before > 10) break;
      end
      nrst = 1'b1; i_valid = 1'b0; q_ready = 1'b1;
      tick(); tick(); tick();
   endtask

`ifdef PIPE_SKID_X4_STALL_CNT_EN
   task automatic test_stall_cnt();
      nrst = 1'b0; tick(); nrst = 1'b1;
      total++; if (stall_cnt !== 16'h0000) begin bad++; $display("FAIL stall_reset0: got %h want 0000", stall_cnt); end
      q_ready = 1'b0; i_valid = 1'b1; i_data = 8'h5A; tick();
      i_valid = 1'b0;
      for (int k = 0; k < 100; k++) tick();
      total++; if (stall_cnt !== 16'(m_stall)) begin bad++; $display("FAIL stall_100: got %0d want %0d", stall_cnt, m_stall); end
      for (int k = 0; k < 69900; k++) tick();
      total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL stall_sat: got %h want ffff", stall_cnt); end
      tick(); tick();
      total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL stall_hold: got %h want ffff", stall_cnt); end
      total++; if (q_valid !== 1'b1 || q_data !== 8'h5A) begin bad++; $display("FAIL stall_data: got v=%b d=%h want v=1 d=5a", q_valid, q_data); end
      nrst = 1'b0; tick(); nrst = 1'b1;
      total++; if (stall_cnt !== 16'h0000) begin bad++; $display("FAIL stall_clear: got %h want 0000", stall_cnt); end
   endtask
`endif

   initial begin
      nrst = 1'b0; i_valid = 1'b0; i_data = 8'h00; q_ready = 1'b0;
      #2;
      test_reset();
      test_streaming();
      test_backpressure();
      test_simultaneous();
      test_midreset();
      test_random();
`ifdef PIPE_SKID_X4_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
